// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, TX/RX state enums and the
// oversampling constant.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_RSVD = 2'd3
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // The reserved encoding behaves like "no parity".
  function automatic logic parityEnabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Payloads narrower than 8 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic calcParity(input logic [7:0] data, input logic [1:0] mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_if.sv
// UART parallel-side bundle: TX/RX valid-ready handshakes, payloads, error
// flags and parity configuration.
interface uart_if #(parameter int DATA_BITS = 8);
  logic [1:0]           parity_mode;
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic [2:0]           rx_err;

  modport master (
    output parity_mode, tx_valid, tx_data, rx_ready,
    input  tx_ready, rx_valid, rx_data, rx_err
  );

  modport slave (
    input  parity_mode, tx_valid, tx_data, rx_ready,
    output tx_ready, rx_valid, rx_data, rx_err
  );
endinterface

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick: one-cycle pulse every DIVISOR clocks, shared
// by the transmitter and the receiver.
module uart_tick_gen #(
  parameter int DIVISOR = 27
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: independent 16x-oversampled transmitter and receiver
// sharing one tick generator; TX and RX may be looped back externally.
module uart_core #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DIVISOR   = 27
) (
  input  logic  clk,
  input  logic  rst_n,
  uart_if.slave bus,
  output logic  tx,
  input  logic  rx
);
  import uart_pkg::*;

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  logic w_tick;

  uart_tick_gen #(.DIVISOR(DIVISOR)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  tx_state_e            r_txState, w_txNext;
  logic [3:0]           r_txTick;
  logic [2:0]           r_txBitIdx;
  logic [DATA_BITS-1:0] r_txShift;
  logic                 r_txParBit;
  logic                 r_txParEn;
  logic                 r_txReady;
  logic                 w_txAccept;
  logic                 w_txBitDone;

  assign w_txAccept  = bus.tx_valid && r_txReady;
  assign w_txBitDone = w_tick && (r_txTick == LAST_TICK);
  assign bus.tx_ready = r_txReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_txState <= TX_IDLE;
    else        r_txState <= w_txNext;
  end

  always_comb begin
    w_txNext = r_txState;
    tx       = 1'b1;
    case (r_txState)
      TX_IDLE:   if (w_txAccept) w_txNext = TX_START;
      TX_START: begin
        tx = 1'b0;
        if (w_txBitDone) w_txNext = TX_DATA;
      end
      TX_DATA: begin
        tx = r_txShift[0];
        if (w_txBitDone && (r_txBitIdx == LAST_DATA))
          w_txNext = r_txParEn ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx = r_txParBit;
        if (w_txBitDone) w_txNext = TX_STOP;
      end
      TX_STOP:   if (w_txBitDone && (r_txBitIdx == LAST_STOP)) w_txNext = TX_IDLE;
      default:   w_txNext = TX_IDLE;
    endcase
  end

  // Ready follows the next state, so it is low in reset and rises one edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txReady  <= 1'b0;
      r_txTick   <= '0;
      r_txBitIdx <= '0;
      r_txShift  <= '0;
      r_txParBit <= 1'b0;
      r_txParEn  <= 1'b0;
    end else begin
      r_txReady <= (w_txNext == TX_IDLE);
      if (w_txAccept) begin
        r_txShift  <= bus.tx_data;
        r_txParEn  <= parityEnabled(bus.parity_mode);
        r_txParBit <= calcParity(8'(bus.tx_data), bus.parity_mode);
      end
      if (r_txState == TX_IDLE) begin
        r_txTick   <= '0;
        r_txBitIdx <= '0;
      end else if (w_tick) begin
        r_txTick <= r_txTick + 4'd1;
        if (w_txBitDone) begin
          r_txBitIdx <= (w_txNext != r_txState) ? 3'd0 : r_txBitIdx + 3'd1;
          if (r_txState == TX_DATA) r_txShift <= r_txShift >> 1;
        end
      end
    end
  end

  rx_state_e            r_rxState, w_rxNext;
  logic                 r_rxMeta, r_rxSync, r_rxPrev;
  logic [3:0]           r_rxTick;
  logic [2:0]           r_rxBitIdx;
  logic [DATA_BITS-1:0] r_rxShift;
  logic [1:0]           r_rxParMode;
  logic                 r_rxParErr;
  logic                 r_rxValid;
  logic [DATA_BITS-1:0] r_rxData;
  logic [2:0]           r_rxErr;
  logic                 w_rxFall;
  logic                 w_rxSample;
  logic                 w_rxDeliver;

  assign w_rxFall    = r_rxPrev && !r_rxSync;
  assign w_rxSample  = w_tick &&
                       (r_rxTick == ((r_rxState == RX_START) ? MID_TICK : LAST_TICK));
  assign w_rxDeliver = (r_rxState == RX_STOP) && w_rxSample;
  assign bus.rx_valid = r_rxValid;
  assign bus.rx_data  = r_rxData;
  assign bus.rx_err   = r_rxErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rxState <= RX_IDLE;
    else        r_rxState <= w_rxNext;
  end

  // Edge detection means a low stop bit cannot re-trigger until the line has gone high.
  always_comb begin
    w_rxNext = r_rxState;
    case (r_rxState)
      RX_IDLE:   if (w_rxFall) w_rxNext = RX_START;
      RX_START:  if (w_rxSample) w_rxNext = r_rxSync ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_rxSample && (r_rxBitIdx == LAST_DATA))
                   w_rxNext = parityEnabled(r_rxParMode) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rxSample) w_rxNext = RX_STOP;
      RX_STOP:   if (w_rxSample) w_rxNext = RX_IDLE;
      default:   w_rxNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxMeta    <= 1'b1;
      r_rxSync    <= 1'b1;
      r_rxPrev    <= 1'b1;
      r_rxTick    <= '0;
      r_rxBitIdx  <= '0;
      r_rxShift   <= '0;
      r_rxParMode <= '0;
      r_rxParErr  <= 1'b0;
    end else begin
      r_rxMeta <= rx;
      r_rxSync <= r_rxMeta;
      r_rxPrev <= r_rxSync;
      if (r_rxState == RX_IDLE) begin
        r_rxTick <= '0;
        if (w_rxFall) begin
          r_rxBitIdx  <= '0;
          r_rxParMode <= bus.parity_mode;
          r_rxParErr  <= 1'b0;
        end
      end else if (w_tick) begin
        r_rxTick <= w_rxSample ? 4'd0 : r_rxTick + 4'd1;
      end
      if (w_rxSample && (r_rxState == RX_DATA)) begin
        r_rxShift  <= {r_rxSync, r_rxShift[DATA_BITS-1:1]};
        r_rxBitIdx <= r_rxBitIdx + 3'd1;
      end
      if (w_rxSample && (r_rxState == RX_PARITY))
        r_rxParErr <= (r_rxSync != calcParity(8'(r_rxShift), r_rxParMode));
    end
  end

  // A word that lands while the previous one is still unaccepted overwrites it and flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxValid <= 1'b0;
      r_rxData  <= '0;
      r_rxErr   <= '0;
    end else if (w_rxDeliver) begin
      r_rxValid <= 1'b1;
      r_rxData  <= r_rxShift;
      r_rxErr   <= {r_rxValid && !bus.rx_ready, r_rxParErr, !r_rxSync};
    end else if (r_rxValid && bus.rx_ready) begin
      r_rxValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core: TX waveform, loopback, RX
// error flags, glitch rejection, overrun and mid-frame reset.
module tb_uart_core;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int DIVISOR   = 2;
  localparam int BIT_CYC   = 16 * DIVISOR;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic rxDrive = 1'b1;
  logic loopEn  = 1'b0;
  logic tx;
  logic rx;
  int   compCount = 0;
  int   errCount  = 0;
  int   cyc;
  logic [10:0] rxQ[$];
  logic [0:10] expA5 = 11'b01010010101;

  uart_if #(.DATA_BITS(DATA_BITS)) bus ();

  assign rx = loopEn ? tx : rxDrive;

  uart_core #(
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (STOP_BITS),
    .DIVISOR   (DIVISOR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .tx    (tx),
    .rx    (rx)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the DUT tick counter runs in lockstep, so odd counts mark tick phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Record every accepted receive word as {rx_err, rx_data}.
  always @(negedge clk) begin
    if (rst_n && bus.rx_valid && bus.rx_ready) rxQ.push_back({bus.rx_err, bus.rx_data});
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitTxReady(input int limit);
    int n = 0;
    while (!bus.tx_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_ready) checkOutput("txReadyTimeout", bus.tx_ready, 1);
  endtask

  // Wait for a negedge where the following edge is even-numbered, i.e. the cycle after it has no tick.
  task automatic alignTick();
    while (cyc % 2 == 0) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] mode);
    waitTxReady(1000);
    alignTick();
    bus.parity_mode = mode;
    bus.tx_data     = data;
    bus.tx_valid    = 1'b1;
    @(negedge clk);
    bus.tx_valid    = 1'b0;
  endtask

  task automatic driveRxFrame(input logic [7:0] data, input logic parEn,
                              input logic parBit, input logic stopBit);
    rxDrive = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxDrive = data[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    if (parEn) begin
      rxDrive = parBit;
      repeat (BIT_CYC) @(negedge clk);
    end
    rxDrive = stopBit;
    repeat (BIT_CYC) @(negedge clk);
    rxDrive = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  function automatic logic [10:0] rxEntry(input int k);
    return (rxQ.size() > k) ? rxQ[k] : 11'h7FF;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [10:0] w;
    bus.parity_mode = 2'd0;
    bus.tx_valid    = 1'b0;
    bus.tx_data     = '0;
    bus.rx_ready    = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("rstTx", tx, 1);
    checkOutput("rstTxReady", bus.tx_ready, 0);
    checkOutput("rstRxValid", bus.rx_valid, 0);
    checkOutput("rstRxData", bus.rx_data, 0);
    checkOutput("rstRxErr", bus.rx_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("txReadyAfterRst", bus.tx_ready, 1);

    // Even parity 0xA5: eleven 32-cycle bits, ready again 352 cycles after accept.
    alignTick();
    bus.parity_mode = 2'd1;
    bus.tx_data     = 8'hA5;
    bus.tx_valid    = 1'b1;
    @(negedge clk);
    bus.tx_valid    = 1'b0;
    checkOutput("txReadyDrop", bus.tx_ready, 0);
    for (int j = 0; j <= 352; j++) begin
      if (j < 352 && (j % 32 == 1 || j % 32 == 30))
        checkOutput($sformatf("txA5bit%0d_c%0d", j / 32, j), tx, expA5[j / 32]);
      if (j == 351) checkOutput("txReadyBusy", bus.tx_ready, 0);
      if (j == 352) begin
        checkOutput("txReadyBack", bus.tx_ready, 1);
        checkOutput("txIdleHigh", tx, 1);
      end
      if (j < 352) @(negedge clk);
    end

    // Loopback, odd parity, two frames back-to-back.
    loopEn = 1'b1;
    rxQ.delete();
    bus.parity_mode = 2'd2;
    bus.tx_data     = 8'h3C;
    bus.tx_valid    = 1'b1;
    @(negedge clk);
    bus.tx_data     = 8'hFF;
    @(negedge clk);
    waitTxReady(1000);
    @(negedge clk);
    bus.tx_valid    = 1'b0;
    for (int n = 0; n < 1200 && rxQ.size() < 2; n++) @(negedge clk);
    checkOutput("loopCount", rxQ.size(), 2);
    w = rxEntry(0);
    checkOutput("loopData0", w[7:0], 8'h3C);
    checkOutput("loopErr0", w[10:8], 3'b000);
    w = rxEntry(1);
    checkOutput("loopData1", w[7:0], 8'hFF);
    checkOutput("loopErr1", w[10:8], 3'b000);

    // Reset during data bit 3 of a looped-back frame.
    rxQ.delete();
    applyStimulus(8'hA5, 2'd1);
    repeat (139) @(negedge clk);
    checkOutput("txBit3Low", tx, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("txRstMidFrame", tx, 1);
    checkOutput("txReadyInRst", bus.tx_ready, 0);
    checkOutput("rxValidInRst", bus.rx_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("txReadyAfterRst2", bus.tx_ready, 1);
    repeat (400) @(negedge clk);
    checkOutput("noPartialRx", rxQ.size(), 0);
    loopEn = 1'b0;

    // 0x55 with even parity: correct parity bit is 0, driven as 1.
    bus.parity_mode = 2'd1;
    repeat (40) @(negedge clk);
    rxQ.delete();
    driveRxFrame(8'h55, 1'b1, 1'b1, 1'b1);
    checkOutput("parCount", rxQ.size(), 1);
    w = rxEntry(0);
    checkOutput("parData", w[7:0], 8'h55);
    checkOutput("parErr", w[10:8], 3'b010);

    // Stop bit low gives framing error; a short low glitch is discarded.
    bus.parity_mode = 2'd0;
    rxQ.delete();
    driveRxFrame(8'h0F, 1'b0, 1'b0, 1'b0);
    checkOutput("frmCount", rxQ.size(), 1);
    w = rxEntry(0);
    checkOutput("frmData", w[7:0], 8'h0F);
    checkOutput("frmErr", w[10:8], 3'b001);
    rxQ.delete();
    rxDrive = 1'b0;
    repeat (5) @(negedge clk);
    rxDrive = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("glitchNoValid", rxQ.size(), 0);
    driveRxFrame(8'hA3, 1'b0, 1'b0, 1'b1);
    checkOutput("postGlitchCount", rxQ.size(), 1);
    w = rxEntry(0);
    checkOutput("postGlitchData", w[7:0], 8'hA3);
    checkOutput("postGlitchErr", w[10:8], 3'b000);

    // Overrun: two words with the consumer stalled.
    bus.rx_ready = 1'b0;
    driveRxFrame(8'h11, 1'b0, 1'b0, 1'b1);
    checkOutput("ovrFirstValid", bus.rx_valid, 1);
    checkOutput("ovrFirstData", bus.rx_data, 8'h11);
    checkOutput("ovrFirstErr", bus.rx_err, 3'b000);
    driveRxFrame(8'h22, 1'b0, 1'b0, 1'b1);
    checkOutput("ovrValid", bus.rx_valid, 1);
    checkOutput("ovrData", bus.rx_data, 8'h22);
    checkOutput("ovrErr", bus.rx_err, 3'b100);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    checkOutput("ovrCleared", bus.rx_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 DATA_BITS, default 8, payload bits per frame, legal 5..8.
REQ-002 STOP_BITS, default 1, stop bits transmitted and checked, legal 1 or 2.
REQ-003 DIVISOR, default 27, clk cycles per oversample tick, legal >=2; one bit time = 16*DIVISOR cycles.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 parity_mode  in  2  0=none, 1=even, 2=odd, 3=reserved and treated as none; sampled only at frame start.
REQ-007 tx_valid  in  1  transmit request.
REQ-008 tx_data  in  DATA_BITS  transmit payload.
REQ-009 tx_ready  out  1  transmitter idle and able to accept.
REQ-010 tx  out  1  serial line out, idle high.
REQ-011 rx  in  1  asynchronous serial line in.
REQ-012 rx_valid  out  1  received word held in rx_data.
REQ-013 rx_ready  in  1  consumer accepts rx_data.
REQ-014 rx_data  out  DATA_BITS  received payload.
REQ-015 rx_err  out  3  {overrun, parity_err, framing_err}, qualified by rx_valid.

Function
REQ-016 Baud: a shared counter shall emit a one-cycle tick every DIVISOR cycles, free-running from reset.
REQ-017 TX handshake: a transfer shall occur when tx_valid && tx_ready; tx_data and parity_mode are latched on that edge and tx_ready drops on the next cycle.
REQ-018 TX FSM: IDLE -> START -> DATA -> PARITY (skipped if none) -> STOP -> IDLE; each state shall last 16 ticks per bit.
REQ-019 TX line: start bit 0, data LSB first, parity bit = XOR of data (even) or its inverse (odd), then STOP_BITS ones.
REQ-020 TX shall return tx_ready=1 on the cycle after the last stop bit completes; back-to-back frames shall have no idle gap beyond one tick.
REQ-021 RX input: rx shall pass through a 2-flop synchroniser before use.
REQ-022 RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
REQ-023 Start: a falling edge in IDLE enters START; the line is re-sampled at tick 8; if high, the frame is discarded as a glitch and the FSM returns to IDLE.
REQ-024 Sampling: each subsequent bit shall be sampled once, 16 ticks after the previous sample (mid-bit).
REQ-025 Framing error: any checked stop bit sampled 0 sets framing_err; the FSM then waits in IDLE for rx high before re-arming.
REQ-026 Parity error: a received parity bit mismatching parity_mode latched at the start bit sets parity_err.
REQ-027 Delivery: after the first stop-bit sample, rx_data and rx_err shall update and rx_valid shall assert on the next cycle; a word with errors is still delivered.
REQ-028 rx_valid shall remain high until rx_valid && rx_ready, then clear on the next cycle unless a new word lands on the same cycle.
REQ-029 Overrun: if a new word completes while rx_valid=1 and rx_ready=0, the new word overwrites rx_data and overrun is set in rx_err.
REQ-030 If completion and acceptance coincide, the new word shall load with overrun=0 and rx_valid shall stay high.
REQ-031 TX and RX shall be fully independent; the external loopback tx->rx shall be legal.

Reset
REQ-032 When rst_n=0: tx=1, tx_ready=0, rx_valid=0, rx_data=0, rx_err=0, both FSMs IDLE, and the tick counter and synchroniser cleared to idle-high.
REQ-033 tx_ready shall rise on the first clk edge after rst_n deasserts.
REQ-034 Reset mid-frame shall abort the frame immediately with no partial delivery.

Structure
REQ-035 A shared package uart_pkg shall hold the parity_mode encodings, the TX/RX state enums, and the oversample constant 16.
REQ-036 The tick generator shall be a single sub-module, uart_tick_gen, parameterised by DIVISOR.

Verification
REQ-037 Use DIVISOR=2, DATA_BITS=8, even parity, tx_data=0xA5 -> tx = 0,1,0,1,0,0,1,0,1,0,1, each bit 32 cycles; tx_ready high again 352 cycles after accept.
REQ-038 With loopback, odd parity, send 0x3C then 0xFF back-to-back with rx_ready=1 -> two rx_valid pulses carrying 0x3C and 0xFF, rx_err=0.
REQ-039 Drive an rx frame of 0x55 with a corrupted parity bit -> rx_data=0x55, rx_err=3'b010.
REQ-040 Drive an rx frame with stop bit 0 -> framing_err=1; a 5-cycle rx low glitch -> no rx_valid.
REQ-041 Hold rx_ready=0 and receive 0x11 then 0x22 -> rx_data=0x22, overrun=1.
REQ-042 Assert rst_n=0 mid-TX data bit 3 -> tx=1 immediately; tx_ready=1 one cycle after release.
